mem_access_unit: RTL and testbench

Load/store initiator sitting between the CPU datapath and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake. Drives the memory's write enable, address and write data, and performs read-modify-write for byte and halfword stores. Returns sign- or zero-extended load data on a valid/ready response channel.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request, response and data-memory signal bundle for mem_access_unit.
// The slave modport is the unit. The master modport is its surroundings: the CPU plus the memory read port.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_wr_en, mem_addr, mem_data_in
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wr_en, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, read-modify-write for sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned accesses instead of truncating them.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 16000
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;
    localparam logic [1:0]  SZ_ILL    = 2'b11;
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic [15:0] data);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            r[{off, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = data;
        end
        return r;
    endfunction

    // Request decode, evaluated against the live request fields in IDLE.
    logic        misaligned;
    logic [32:0] addr_end;
    logic        req_err;
    logic [1:0]  eff_off;

    always_comb begin
`ifdef MAU_MISALIGN_TRAP_EN
        misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                     ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        addr_end = {1'b0, bus.req_addr} + {30'd0, size_bytes(bus.req_size)};
        req_err  = (bus.req_size == SZ_ILL) || (addr_end > MEM_LIMIT) || misaligned;
        case (bus.req_size)
            SZ_BYTE: eff_off = bus.req_addr[1:0];
            SZ_HALF: eff_off = {bus.req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        off_d         = off_q;
        wdata_d       = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    write_d     = bus.req_write;
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    off_d       = eff_off;
                    wdata_d     = bus.req_wdata[15:0];
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                            mem_wr_en_d   = 1'b1;
                            mem_data_in_d = bus.req_wdata;
                            state_d       = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                // The read word is consumed at this edge; no separate capture register is needed.
                if (write_q) begin
                    mem_wr_en_d   = 1'b1;
                    mem_data_in_d = merge_store(bus.mem_data_out, size_q, off_q, wdata_q);
                    state_d       = WRITE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = extract_load(bus.mem_data_out, size_q, off_q, signed_q);
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    // Memory strobes come straight from flops, so the level-sensitive memory never sees glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'h0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_data_in_q <= 32'h0;
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            off_q         <= 2'b00;
            wdata_q       <= 16'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            write_q       <= write_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory plus a byte-addressed reference model.
// Directed test-plan steps come first, then randomized requests.
module tb_mem_access_unit;
    localparam int unsigned MEM_BYTES = 16000;
`ifdef MAU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory that the DUT talks to: combinational read, write while mem_wr_en is high.
    logic [31:0] mem_words [0:MEM_BYTES/4-1];
    always_comb begin
        bus.mem_data_out = 32'h0;
        if (bus.mem_addr < MEM_BYTES) bus.mem_data_out = mem_words[bus.mem_addr[13:2]];
    end
    always @(posedge clk) begin
        if (bus.mem_wr_en && (bus.mem_addr < MEM_BYTES)) mem_words[bus.mem_addr[13:2]] <= bus.mem_data_in;
    end

    // Reference: a plain byte array
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    int total = 0;
    int bad = 0;
    logic [31:0] got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int b);
        if (b < 0 || b > int'(MEM_BYTES) - 4) return 32'h0;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd, output int base);
        int n;
        logic [63:0] last;
        logic [31:0] val;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        last = 64'(a) + 64'(n);
        err  = (sz == 2'b11) || (last > 64'(MEM_BYTES)) || (TRAP && ((a % 32'(n)) != 0));
        base = int'(a - (a % 32'(n)));
        rd   = 32'h0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[base+i]) << (8*i));
                if (sg && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                rd = val;
            end
        end
    endtask

    // One full transaction, entered and left at a negedge with req_ready expected high.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] obs_rd);
        logic        exp_err;
        logic [31:0] exp_rd, wr_addr, wr_data, rd_seen, exp_word;
        int          base, wbase, lat, wr_cnt, rdy_seen, exp_lat;
        bit          done;
        model(w, sz, sg, a, wd, exp_err, exp_rd, base);
        wbase    = base & ~3;
        exp_word = ref_word(wbase);
        exp_lat  = exp_err ? 1 : ((w && sz != 2'b10) ? 3 : 2);
        check($sformatf("%s:ready_in", tag), {31'b0, bus.req_ready}, 32'h1);

        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        lat = 0; wr_cnt = 0; rdy_seen = 0; done = 0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_wr_en) begin wr_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_data_in; end
            if (bus.req_ready) rdy_seen++;
            if (bus.resp_valid) begin done = 1; break; end
            // Junk on the request port while busy must be ignored.
            bus.req_valid = 1'b1; bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
        end
        bus.req_valid = 1'b0;
        obs_rd = 32'h0;
        if (!done) begin
            total++; bad++;
            $error("FAIL %s:timeout: observed=no response expected=response within 8 cycles", tag);
            return;
        end
        rd_seen = bus.resp_rdata;
        obs_rd  = rd_seen;
        check($sformatf("%s:latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s:ready_busy", tag), 32'(rdy_seen), 32'h0);
        check($sformatf("%s:wr_cycles", tag), 32'(wr_cnt), (!exp_err && w) ? 32'h1 : 32'h0);
        check($sformatf("%s:err", tag), {31'b0, bus.resp_err}, {31'b0, exp_err});
        check($sformatf("%s:rdata", tag), rd_seen, exp_rd);
        if (!exp_err && w) begin
            check($sformatf("%s:wr_addr", tag), wr_addr, 32'(wbase));
            check($sformatf("%s:wr_data", tag), wr_data, exp_word);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s:hold_valid", tag), {31'b0, bus.resp_valid}, 32'h1);
            check($sformatf("%s:hold_err", tag), {31'b0, bus.resp_err}, {31'b0, exp_err});
            check($sformatf("%s:hold_rdata", tag), bus.resp_rdata, exp_rd);
            check($sformatf("%s:hold_ready", tag), {31'b0, bus.req_ready}, 32'h0);
            check($sformatf("%s:hold_wr_en", tag), {31'b0, bus.mem_wr_en}, 32'h0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check($sformatf("%s:valid_done", tag), {31'b0, bus.resp_valid}, 32'h0);
        check($sformatf("%s:ready_done", tag), {31'b0, bus.req_ready}, 32'h1);
        if (!exp_err && w) check($sformatf("%s:mem", tag), mem_words[wbase/4], ref_word(wbase));
    endtask

    initial begin
        logic [31:0] w;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
        for (int i = 0; i < int'(MEM_BYTES) / 4; i++) begin
            w = $urandom;
            mem_words[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[8*j +: 8];
        end

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_wr_en", {31'b0, bus.mem_wr_en}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_data_in", bus.mem_data_in, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_req("tp_wst", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
        run_req("tp_wld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got);
        check("tp_wld_val", got, 32'hDEADBEEF);

        run_req("tp_init", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0, got);
        run_req("tp_bst", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AB, 0, got);
        check("tp_bst_word", mem_words[4], 32'h1122AB44);
        run_req("tp_lb", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, got);
        check("tp_lb_val", got, 32'hFFFFFFAB);
        run_req("tp_lbu", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, got);
        check("tp_lbu_val", got, 32'h000000AB);

        run_req("tp_hinit", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80010000, 0, got);
        run_req("tp_lh", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, got);
        check("tp_lh_val", got, 32'hFFFF8001);
        run_req("tp_misal", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, got);
        check("tp_misal_val", got, TRAP ? 32'h0 : 32'h80010000);
        run_req("tp_sh_misal", 1'b1, 2'b01, 1'b0, 32'h15, 32'h0000CAFE, 0, got);

        run_req("tp_oor", 1'b1, 2'b10, 1'b0, 32'd15998, 32'h55AA55AA, 0, got);
        run_req("tp_ill_st", 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 0, got);
        run_req("tp_ill_ld", 1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 0, got);
        run_req("tp_last_w", 1'b0, 2'b10, 1'b0, 32'd15996, 32'h0, 0, got);
        run_req("tp_last_b", 1'b1, 2'b00, 1'b0, 32'd15999, 32'h000000C3, 0, got);
        run_req("tp_last_h", 1'b0, 2'b01, 1'b1, 32'd15999, 32'h0, 0, got);
        run_req("tp_wrap", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 0, got);

        run_req("tp_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, got);
        run_req("tp_hold_err", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 3, got);

        // Reset during WRITE: store the word already there so either outcome keeps the model valid.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = ref_word(32'h20);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstw_wr_en_before", {31'b0, bus.mem_wr_en}, 32'h1);
        reset = 1'b1;
        #1;
        check("rstw_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rstw_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rstw_wr_en", {31'b0, bus.mem_wr_en}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstw_mem", mem_words[8], ref_word(32'h20));
        check("rstw_idle_valid", {31'b0, bus.resp_valid}, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(16010, 15984))
                                             : 32'($urandom_range(63, 0));
            run_req($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom), 1'($urandom), ra,
                    $urandom, int'($urandom_range(2, 0)), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
